tim_clken: RTL and testbench
============================

Name: tim_clken

Overview:
- Parametrised successor to the cog clock-mux timing block.
- Instead of switching clock nets through muxes, it runs entirely on clock_160 and emits single-cycle clock enables: clk_en at cog rate and clk_en_pll at twice cog rate.
- Adds three behaviours: mode changes applied only on a period boundary (glitch-free), an emulated PLL lock delay, and a stall when a PLL mode is selected with the PLL or oscillator disabled.
- Feeds the cog/hub enable tree.

Parameters:
SLOW_BITS, 13, RCSLOW divider width; RCSLOW period = 2^SLOW_BITS clock_160 cycles (min 6).
LOCK_CYCLES, 1024, clock_160 cycles from PLLENA request to pll_locked (min 1).
LOCK_W, 11, lock counter width; must hold LOCK_CYCLES.

Ports:
clock_160   in   1   master clock, nominally 160MHz
res_n       in   1   reset, asynchronous, active-low
cfg         in   7   CLK register LSBs {PLLENA,OSCENA,OSCM1,OSCM0,CLKSEL[2:0]}
cfg_wr      in   1   one-cycle strobe; captures cfg
clk_en      out  1   one-cycle pulse, once per cog period
clk_en_pll  out  1   one-cycle pulse, twice per cog period
mode        out  5   applied clksel = {cfg[6:5],cfg[2:0]}
switching   out  1   a captured mode is pending (lock or boundary wait)
pll_locked  out  1   emulated PLL locked
stalled     out  1   applied mode produces no enables

Behaviour:
- Reset is asynchronous, active-low, using one clock (clock_160).
- Reset values: mode=00000 (RCFAST), cnt=15, lock counter 0, state RUN, and all outputs 0.
- Period P, in clock_160 cycles, selected by clksel:
  - [2:0]=000 RCFAST: P=16
  - [2:0]=001 RCSLOW: P=2^SLOW_BITS
  - [2:0]=010 XINPUT: P=32
  - [2:0]=011..111 with [4:3]=11: PLLx1, x2, x4, x8, x16 give P=32, 16, 8, 4, 2
  - [2:0]=011..111 with [4:3]!=11: STALL
- Down-counter cnt, width SLOW_BITS, updated every edge in RUN, LOCK and WAIT_EDGE:
  - cnt==0: cnt<=P-1, clk_en<=1.
  - otherwise: cnt<=cnt-1, clk_en<=0.
  - clk_en_pll <= (cnt==0)||(cnt==P/2). At P=2 this is every cycle.
- Both enables are registered. The first clk_en after reset release appears after edge 16.
- States:
  - RUN: no pending change.
  - LOCK: old mode keeps running; the lock counter increments.
  - WAIT_EDGE: old mode keeps running until cnt==0.
  - STALL: no enables are produced; cnt is held at 0; stalled=1.
- cfg_wr handling:
  - pending<=clksel(cfg).
  - If pending equals mode and state is RUN or STALL: ignored.
  - Else, if pending[4]=1 and pll_locked=0: go to LOCK. An LOCK already in progress is not restarted.
  - Else: go to WAIT_EDGE. From STALL the change is applied on the next edge instead.
  - switching<=1 in every accepted case.
- LOCK: when the counter reaches LOCK_CYCLES-1, set pll_locked<=1 and go to WAIT_EDGE.
- WAIT_EDGE at an edge with cnt==0:
  - The old-period pulse is emitted (clk_en=1).
  - mode<=pending; cnt<=P(pending)-1; switching<=0.
  - Next state is RUN, or STALL if pending is a stall mode.
- Applying a mode with bit4 (PLLENA)=0 clears pll_locked and the lock counter.
- cfg_wr while switching: pending is overwritten and re-evaluated as above. A write that requires no lock moves LOCK to WAIT_EDGE; the lock counter is held, not cleared.
- cfg_wr on the same edge as a WAIT_EDGE apply: the apply uses the old pending; the new write is evaluated on the following edge as a fresh change.
- Reset mid-switch or mid-lock: everything returns to reset values immediately; pending is discarded.
- No pulse is ever shorter than one cycle. Successive clk_en pulses are spaced at exactly the old P or the new P, never a partial period.

Test Plan:
- Reset release, no cfg_wr → clk_en after edges 16, 32, 48; clk_en_pll after edges 8, 16, 24; mode=00000.
- cfg_wr cfg=0x6F (PLLx16, PLLENA rising) → switching=1 and pll_locked=0 for 1024 edges. Then pll_locked=1, switch at next cnt==0, then clk_en every 2 edges and clk_en_pll every edge; mode=11111.
- In PLLx16, cfg_wr cfg=0x6C (PLLx2) → no lock; switch at next boundary; clk_en spacing 2 before, 16 after, with no gap shorter than 2.
- cfg_wr cfg=0x0F (PLL16 select, PLL off) → after boundary stalled=1, clk_en=0 for 100+ edges. Then cfg_wr 0x00 → RCFAST applied next edge; first pulse 16 edges later.
- cfg_wr 0x6E, then 0x01 at lock count 500 → leaves LOCK; RCSLOW applied at next boundary; pll_locked=0; clk_en every 8192 edges.
- res_n low mid-LOCK (count 300) → outputs 0 asynchronously; after release, RCFAST timing identical to the first scenario.

Source files
------------

// File: rtl/tim_clken.sv
// tim_clken: cog clock-enable generator running entirely on clock_160.
// Emits single-cycle enables at cog rate (clk_en) and twice cog rate
// (clk_en_pll). Mode changes take effect only on a period boundary, PLL
// modes wait for an emulated lock delay, and invalid PLL selections stall.
//
// state      | meaning
// -----------+---------------------------------------------------------
// RUN        | applied mode running, nothing pending
// LOCK       | old mode running, lock counter advancing toward lock
// WAIT_EDGE  | old mode running until cnt==0, then pending is applied
// STALL      | applied mode is invalid; no enables, cnt held at 0
module tim_clken #(
  parameter int SLOW_BITS   = 13,
  parameter int LOCK_CYCLES = 1024,
  parameter int LOCK_W      = 11
) (
  input  logic       clock_160,
  input  logic       res_n,
  input  logic [6:0] cfg,
  input  logic       cfg_wr,
  output logic       clk_en,
  output logic       clk_en_pll,
  output logic [4:0] mode,
  output logic       switching,
  output logic       pll_locked,
  output logic       stalled
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOCK      = 2'd1,
    ST_WAIT_EDGE = 2'd2,
    ST_STALL     = 2'd3
  } state_t;

  localparam logic [LOCK_W-1:0]    LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [SLOW_BITS-1:0] CNT_RST   = SLOW_BITS'(15);
  localparam logic [SLOW_BITS-1:0] CNT_ONE   = SLOW_BITS'(1);

  // PLL multiplier selections are only meaningful with PLL and oscillator on
  function automatic logic is_stall(input logic [4:0] sel);
    return (sel[2:0] >= 3'd3) && (sel[4:3] != 2'b11);
  endfunction

  // Period minus one, in clock_160 cycles, for a non-stall selection
  function automatic logic [SLOW_BITS-1:0] period_m1(input logic [4:0] sel);
    logic [SLOW_BITS-1:0] p;
    p = '0;
    case (sel[2:0])
      3'd0:    p = SLOW_BITS'(15);
      3'd1:    p = '1;
      3'd2:    p = SLOW_BITS'(31);
      3'd3:    p = SLOW_BITS'(31);
      3'd4:    p = SLOW_BITS'(15);
      3'd5:    p = SLOW_BITS'(7);
      3'd6:    p = SLOW_BITS'(3);
      default: p = SLOW_BITS'(1);
    endcase
    return p;
  endfunction

  state_t               state_q, state_d;
  logic [4:0]           mode_q, mode_d;
  logic [4:0]           pending_q, pending_d;
  logic [SLOW_BITS-1:0] cnt_q, cnt_d;
  logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic                 pll_locked_q, pll_locked_d;
  logic                 clk_en_q, clk_en_d;
  logic                 clk_en_pll_q, clk_en_pll_d;
  logic                 defer_q, defer_d;
  logic [4:0]           defer_sel_q, defer_sel_d;

  logic [4:0]           cfg_sel;
  logic [4:0]           wr_sel;
  logic                 wr_eval;
  logic                 wr_ignored;
  logic                 wr_accept;
  logic                 apply;
  logic                 lock_done;
  logic                 mode_stall;
  logic [SLOW_BITS-1:0] cur_pm1;
  logic [SLOW_BITS-1:0] cur_half;
  logic                 unused_osc_mode;

  // Oscillator drive-mode bits have no effect on enable timing
  assign unused_osc_mode = ^cfg[4:3];

  assign cfg_sel    = {cfg[6:5], cfg[2:0]};
  // A write landing on an apply edge is replayed one cycle later
  assign wr_eval    = cfg_wr | defer_q;
  assign wr_sel     = cfg_wr ? cfg_sel : defer_sel_q;
  assign mode_stall = is_stall(mode_q);
  assign cur_pm1    = period_m1(mode_q);
  assign cur_half   = (cur_pm1 >> 1) + CNT_ONE;
  assign apply      = (state_q == ST_WAIT_EDGE) && (cnt_q == '0);
  assign lock_done  = (state_q == ST_LOCK) && (lock_cnt_q == LOCK_LAST);
  assign wr_ignored = (wr_sel == mode_q) &&
                      ((state_q == ST_RUN) || (state_q == ST_STALL));
  assign wr_accept  = wr_eval && !apply && !wr_ignored;

  // State register
  always_ff @(posedge clock_160 or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: apply at boundary, accept writes, finish lock
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    defer_d     = 1'b0;
    defer_sel_d = defer_sel_q;
    if (apply) begin
      state_d     = is_stall(pending_q) ? ST_STALL : ST_RUN;
      defer_d     = wr_eval;
      defer_sel_d = wr_sel;
    end else if (wr_accept) begin
      pending_d = wr_sel;
      if (wr_sel[4] && !pll_locked_q && !lock_done) begin
        state_d = ST_LOCK;
      end else begin
        state_d = ST_WAIT_EDGE;
      end
    end else if (lock_done) begin
      state_d = ST_WAIT_EDGE;
    end
  end

  // Period counter, enables, applied mode and lock emulation
  always_comb begin
    cnt_d        = cnt_q;
    clk_en_d     = 1'b0;
    clk_en_pll_d = 1'b0;
    mode_d       = mode_q;
    lock_cnt_d   = lock_cnt_q;
    pll_locked_d = pll_locked_q;
    if (mode_stall) begin
      cnt_d = '0;
    end else begin
      clk_en_d     = (cnt_q == '0);
      clk_en_pll_d = (cnt_q == '0) || (cnt_q == cur_half);
      cnt_d        = (cnt_q == '0) ? cur_pm1 : cnt_q - CNT_ONE;
    end
    if (apply) begin
      mode_d = pending_q;
      cnt_d  = is_stall(pending_q) ? '0 : period_m1(pending_q);
      if (!pending_q[4]) begin
        pll_locked_d = 1'b0;
        lock_cnt_d   = '0;
      end
    end
    if (lock_done) begin
      pll_locked_d = 1'b1;
    end else if (state_q == ST_LOCK) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clock_160 or negedge res_n) begin
    if (!res_n) begin
      mode_q       <= '0;
      pending_q    <= '0;
      cnt_q        <= CNT_RST;
      lock_cnt_q   <= '0;
      pll_locked_q <= 1'b0;
      clk_en_q     <= 1'b0;
      clk_en_pll_q <= 1'b0;
      defer_q      <= 1'b0;
      defer_sel_q  <= '0;
    end else begin
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      pll_locked_q <= pll_locked_d;
      clk_en_q     <= clk_en_d;
      clk_en_pll_q <= clk_en_pll_d;
      defer_q      <= defer_d;
      defer_sel_q  <= defer_sel_d;
    end
  end

  // Status outputs decoded from state and applied mode
  always_comb begin
    switching = (state_q == ST_LOCK) || (state_q == ST_WAIT_EDGE);
    stalled   = mode_stall;
  end

  assign clk_en     = clk_en_q;
  assign clk_en_pll = clk_en_pll_q;
  assign mode       = mode_q;
  assign pll_locked = pll_locked_q;

endmodule

// File: tb/tb_tim_clken.sv
// tb_tim_clken: directed scenarios for tim_clken. Expected pulse cycles are
// queued up front; a negedge monitor matches every observed pulse against
// the queues, while the stimulus process checks status outputs directly.
module tb_tim_clken;

  logic       clock_160 = 1'b0;
  logic       res_n     = 1'b0;
  logic [6:0] cfg       = '0;
  logic       cfg_wr    = 1'b0;
  logic       clk_en;
  logic       clk_en_pll;
  logic [4:0] mode;
  logic       switching;
  logic       pll_locked;
  logic       stalled;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int q_en[$];
  int q_pll[$];
  int mon_e;

  tim_clken dut (
    .clock_160  (clock_160),
    .res_n      (res_n),
    .cfg        (cfg),
    .cfg_wr     (cfg_wr),
    .clk_en     (clk_en),
    .clk_en_pll (clk_en_pll),
    .mode       (mode),
    .switching  (switching),
    .pll_locked (pll_locked),
    .stalled    (stalled)
  );

  always #5 clock_160 = ~clock_160;

  // Edge count since reset release: after edge k, cyc == k
  always @(posedge clock_160 or negedge res_n) begin
    if (!res_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every pulse must match the head of its expectation queue
  always @(negedge clock_160) begin
    if (res_n) begin
      while (q_en.size() > 0 && q_en[0] < cyc) begin
        mon_e = q_en.pop_front();
        chk("clk_en_missing", cyc, mon_e);
      end
      if (clk_en) begin
        if (q_en.size() == 0) chk("clk_en_unexpected", cyc, -1);
        else begin
          mon_e = q_en.pop_front();
          chk("clk_en_time", cyc, mon_e);
        end
      end
      while (q_pll.size() > 0 && q_pll[0] < cyc) begin
        mon_e = q_pll.pop_front();
        chk("clk_en_pll_missing", cyc, mon_e);
      end
      if (clk_en_pll) begin
        if (q_pll.size() == 0) chk("clk_en_pll_unexpected", cyc, -1);
        else begin
          mon_e = q_pll.pop_front();
          chk("clk_en_pll_time", cyc, mon_e);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock_160);
  endtask

  // Present cfg so that it is captured by edge w
  task automatic write_at(input int w, input logic [6:0] v);
    wait_cyc(w - 1);
    cfg    = v;
    cfg_wr = 1'b1;
    @(negedge clock_160);
    cfg_wr = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_clk_en"},     int'(clk_en),     0);
    chk({tag, "_clk_en_pll"}, int'(clk_en_pll), 0);
    chk({tag, "_mode"},       int'(mode),       0);
    chk({tag, "_switching"},  int'(switching),  0);
    chk({tag, "_pll_locked"}, int'(pll_locked), 0);
    chk({tag, "_stalled"},    int'(stalled),    0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock_160);
    chk_idle("reset");

    // RCFAST from reset, PLLx16 after lock, PLLx2, stall, RCFAST, RCSLOW
    for (int t = 16; t <= 1088; t += 16) q_en.push_back(t);
    for (int t = 1090; t <= 1102; t += 2) q_en.push_back(t);
    for (int t = 1118; t <= 1150; t += 16) q_en.push_back(t);
    for (int t = 1287; t <= 1815; t += 16) q_en.push_back(t);
    q_en.push_back(10007);
    q_en.push_back(18199);
    for (int t = 8; t <= 1088; t += 8) q_pll.push_back(t);
    for (int t = 1089; t <= 1102; t++) q_pll.push_back(t);
    for (int t = 1110; t <= 1150; t += 8) q_pll.push_back(t);
    for (int t = 1279; t <= 1815; t += 8) q_pll.push_back(t);
    q_pll.push_back(5911);
    q_pll.push_back(10007);
    q_pll.push_back(14103);
    q_pll.push_back(18199);

    res_n = 1'b1;

    write_at(30, 7'h00);
    chk("same_mode_ignored", int'(switching), 0);

    write_at(50, 7'h6F);
    chk("lock_start_switching", int'(switching), 1);
    chk("lock_start_locked", int'(pll_locked), 0);
    wait_cyc(1073);
    chk("lock_pre_locked", int'(pll_locked), 0);
    chk("lock_pre_switching", int'(switching), 1);
    wait_cyc(1074);
    chk("lock_done_locked", int'(pll_locked), 1);
    wait_cyc(1087);
    chk("pre_apply_mode", int'(mode), 0);
    wait_cyc(1088);
    chk("x16_mode", int'(mode), 5'h1F);
    chk("x16_switching", int'(switching), 0);

    write_at(1101, 7'h6C);
    chk("x2_pending_switching", int'(switching), 1);
    wait_cyc(1102);
    chk("x2_mode", int'(mode), 5'h1C);
    chk("x2_switching", int'(switching), 0);
    chk("x2_locked", int'(pll_locked), 1);

    write_at(1140, 7'h0F);
    wait_cyc(1149);
    chk("pre_stall_stalled", int'(stalled), 0);
    wait_cyc(1150);
    chk("stall_mode", int'(mode), 5'h07);
    chk("stall_stalled", int'(stalled), 1);
    chk("stall_locked", int'(pll_locked), 0);
    wait_cyc(1260);
    chk("stall_held", int'(stalled), 1);

    write_at(1270, 7'h00);
    wait_cyc(1271);
    chk("unstall_mode", int'(mode), 0);
    chk("unstall_stalled", int'(stalled), 0);

    write_at(1300, 7'h6E);
    chk("relock_switching", int'(switching), 1);
    write_at(1801, 7'h01);
    wait_cyc(1810);
    chk("abort_switching", int'(switching), 1);
    chk("abort_locked", int'(pll_locked), 0);
    chk("abort_old_mode", int'(mode), 0);
    wait_cyc(1815);
    chk("slow_mode", int'(mode), 5'h01);
    chk("slow_switching", int'(switching), 0);
    chk("slow_locked", int'(pll_locked), 0);

    write_at(18210, 7'h6F);
    wait_cyc(18500);
    chk("midlock_switching", int'(switching), 1);
    chk("midlock_locked", int'(pll_locked), 0);
    chk("seg1_en_queue_empty", q_en.size(), 0);
    chk("seg1_pll_queue_empty", q_pll.size(), 0);

    wait_cyc(18510);
    #2 res_n = 1'b0;
    #1 chk_idle("async_reset");
    @(negedge clock_160);
    @(negedge clock_160);
    chk_idle("held_reset");

    for (int t = 16; t <= 48; t += 16) q_en.push_back(t);
    for (int t = 8; t <= 56; t += 8) q_pll.push_back(t);
    res_n = 1'b1;
    wait_cyc(60);
    chk("post_reset_mode", int'(mode), 0);
    chk("post_reset_switching", int'(switching), 0);
    chk("seg2_en_queue_empty", q_en.size(), 0);
    chk("seg2_pll_queue_empty", q_pll.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
